reservation_station: RTL and testbench

- Receiving end of the decoder's issue interface for ALU-class instructions: OP, OP-IMM, JAL, JALR, BRANCH, LUI and AUIPC.
- Buffers up to `RS_SIZE` issued instructions and snoops the ALU and LSB result broadcasts to resolve pending operand tags.
- Dispatches one fully-ready instruction per cycle to the ALU over a registered interface.
- Sits between the decoder/ROB issue path and the ALU.
- Drives `rs_nxt_full` back to instruction fetch as an issue stall.

---
 rtl/reservation_station.sv | 182 ++++++++++++++++++
 tb/tb_reservation_station.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: buffers issued ops, resolves
// pending operand tags from the ALU/LSB broadcasts, dispatches one ready op per cycle.
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,

    input  logic        rs_en,
    input  logic [3:0]  issue_rob_pos,
    input  logic [6:0]  issue_opcode,
    input  logic [2:0]  issue_funct3,
    input  logic        issue_funct7,
    input  logic [31:0] issue_rs1_val,
    input  logic [4:0]  issue_rs1_rob_id,
    input  logic [31:0] issue_rs2_val,
    input  logic [4:0]  issue_rs2_rob_id,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_pc,
    output logic        rs_nxt_full,

    input  logic        alu_result,
    input  logic [3:0]  alu_result_rob_pos,
    input  logic [31:0] alu_result_val,
    input  logic        lsb_result,
    input  logic [3:0]  lsb_result_rob_pos,
    input  logic [31:0] lsb_result_val,

    output logic        alu_en,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic        alu_funct7,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [3:0]  alu_rob_pos
);

    localparam logic [RS_IDX_W:0] FULL_CNT   = (RS_IDX_W+1)'(RS_SIZE);
    localparam logic [RS_IDX_W:0] ALMOST_CNT = (RS_IDX_W+1)'(RS_SIZE - 1);

    // Returns {tag, val} after snooping both broadcasts; a resolved tag becomes 0.
    function automatic logic [36:0] wake(
        input logic [4:0]  tag,
        input logic [31:0] val,
        input logic        a_v,
        input logic [3:0]  a_pos,
        input logic [31:0] a_val,
        input logic        l_v,
        input logic [3:0]  l_pos,
        input logic [31:0] l_val
    );
        logic [36:0] res;
        res = {tag, val};
        if (a_v && tag == {1'b1, a_pos}) res = {5'd0, a_val};
        if (l_v && tag == {1'b1, l_pos}) res = {5'd0, l_val};
        return res;
    endfunction

    logic [RS_SIZE-1:0] busy_reg;
    logic [RS_SIZE-1:0] ready;
    logic [6:0]         opcode_reg [RS_SIZE];
    logic [2:0]         funct3_reg [RS_SIZE];
    logic               funct7_reg [RS_SIZE];
    logic [31:0]        val1_reg   [RS_SIZE];
    logic [4:0]         tag1_reg   [RS_SIZE];
    logic [31:0]        val2_reg   [RS_SIZE];
    logic [4:0]         tag2_reg   [RS_SIZE];
    logic [31:0]        imm_reg    [RS_SIZE];
    logic [31:0]        pc_reg     [RS_SIZE];
    logic [3:0]         rob_reg    [RS_SIZE];

    logic                disp_fire, ins_fire, has_free;
    logic [RS_IDX_W-1:0] disp_idx, ins_idx;
    logic [RS_IDX_W:0]   busy_cnt;
    logic [36:0]         issue_w1, issue_w2;

    assign issue_w1 = wake(issue_rs1_rob_id, issue_rs1_val, alu_result, alu_result_rob_pos,
                           alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val);
    assign issue_w2 = wake(issue_rs2_rob_id, issue_rs2_val, alu_result, alu_result_rob_pos,
                           alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val);

    // Lowest-index ready entry dispatches, lowest-index free entry takes the issue.
    // Both look only at pre-edge state, so a slot freed this cycle is reused next cycle.
    always_comb begin
        disp_fire = 1'b0;
        disp_idx  = '0;
        has_free  = 1'b0;
        ins_idx   = '0;
        busy_cnt  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_fire = 1'b1;
                disp_idx  = RS_IDX_W'(i);
            end
            if (!busy_reg[i]) begin
                has_free = 1'b1;
                ins_idx  = RS_IDX_W'(i);
            end
            busy_cnt = busy_cnt + {{RS_IDX_W{1'b0}}, busy_reg[i]};
        end
        ins_fire = rs_en && has_free;
    end

    assign rs_nxt_full = (busy_cnt == FULL_CNT) || (busy_cnt == ALMOST_CNT && rs_en);

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic [36:0] w1, w2;
            logic        ins_here, disp_here;

            assign w1 = wake(tag1_reg[gi], val1_reg[gi], alu_result, alu_result_rob_pos,
                             alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val);
            assign w2 = wake(tag2_reg[gi], val2_reg[gi], alu_result, alu_result_rob_pos,
                             alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val);
            assign ready[gi]  = busy_reg[gi] && !tag1_reg[gi][4] && !tag2_reg[gi][4];
            assign ins_here   = ins_fire && (ins_idx == RS_IDX_W'(gi));
            assign disp_here  = disp_fire && (disp_idx == RS_IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (rst || rollback) begin
                    busy_reg[gi] <= 1'b0;
                end else if (rdy) begin
                    if (ins_here)       busy_reg[gi] <= 1'b1;
                    else if (disp_here) busy_reg[gi] <= 1'b0;
                end
            end

            // Payload needs no reset: it is only consumed while busy is set.
            always_ff @(posedge clk) begin
                if (!rst && !rollback && rdy) begin
                    if (ins_here) begin
                        opcode_reg[gi] <= issue_opcode;
                        funct3_reg[gi] <= issue_funct3;
                        funct7_reg[gi] <= issue_funct7;
                        {tag1_reg[gi], val1_reg[gi]} <= issue_w1;
                        {tag2_reg[gi], val2_reg[gi]} <= issue_w2;
                        imm_reg[gi]    <= issue_imm;
                        pc_reg[gi]     <= issue_pc;
                        rob_reg[gi]    <= issue_rob_pos;
                    end else if (busy_reg[gi]) begin
                        {tag1_reg[gi], val1_reg[gi]} <= w1;
                        {tag2_reg[gi], val2_reg[gi]} <= w2;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rollback) begin
            alu_en <= 1'b0;
        end else if (rdy) begin
            alu_en <= disp_fire;
            if (disp_fire) begin
                alu_opcode  <= opcode_reg[disp_idx];
                alu_funct3  <= funct3_reg[disp_idx];
                alu_funct7  <= funct7_reg[disp_idx];
                alu_val1    <= val1_reg[disp_idx];
                alu_val2    <= val2_reg[disp_idx];
                alu_imm     <= imm_reg[disp_idx];
                alu_pc      <= pc_reg[disp_idx];
                alu_rob_pos <= rob_reg[disp_idx];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed-vector bench for reservation_station: issue, wakeup, fill/drain,
// rollback and rdy-stall scenarios with hand-computed expectations.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        rs_en;
    logic [3:0]  issue_rob_pos;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic [4:0]  issue_rs1_rob_id, issue_rs2_rob_id;
    logic        rs_nxt_full;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;
    logic        alu_en, alu_funct7;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    reservation_station #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .rs_en(rs_en), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_rs1_val(issue_rs1_val), .issue_rs1_rob_id(issue_rs1_rob_id),
        .issue_rs2_val(issue_rs2_val), .issue_rs2_rob_id(issue_rs2_rob_id),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .rs_nxt_full(rs_nxt_full),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
        .alu_result_val(alu_result_val), .lsb_result(lsb_result),
        .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_set(input logic [3:0] rob, input logic [6:0] op,
                             input logic [31:0] v1, input logic [4:0] t1,
                             input logic [31:0] v2, input logic [4:0] t2,
                             input logic [31:0] imm, input logic [31:0] pc);
        rs_en            = 1'b1;
        issue_rob_pos    = rob;
        issue_opcode     = op;
        issue_funct3     = 3'd0;
        issue_funct7     = 1'b0;
        issue_rs1_val    = v1;
        issue_rs1_rob_id = t1;
        issue_rs2_val    = v2;
        issue_rs2_rob_id = t2;
        issue_imm        = imm;
        issue_pc         = pc;
        $display("issue rob=%0d op=%b t1=%h t2=%h v1=%h v2=%h", rob, op, t1, t2, v1, v2);
    endtask

    task automatic quiet();
        rs_en      = 1'b0;
        alu_result = 1'b0;
        lsb_result = 1'b0;
        rollback   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rs_en = 1'b0;
        issue_rob_pos = '0; issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
        issue_rs1_val = '0; issue_rs1_rob_id = '0; issue_rs2_val = '0; issue_rs2_rob_id = '0;
        issue_imm = '0; issue_pc = '0;
        alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
        lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_en", alu_en, 0);
        check("rst_val1", alu_val1, 0);
        check("rst_imm", alu_imm, 0);
        check("rst_rob", alu_rob_pos, 0);
        check("rst_op", alu_opcode, 0);
        check("rst_pc", alu_pc, 0);
        check("rst_full", rs_nxt_full, 0);

        // ADDI, operands ready: two-edge latency
        issue_set(4'd2, OP_IMM, 32'd5, 5'h00, 32'd0, 5'h00, 32'd3, 32'h100);
        tick(); quiet();
        check("addi_lat1", alu_en, 0);
        tick();
        check("addi_en", alu_en, 1);
        check("addi_val1", alu_val1, 5);
        check("addi_imm", alu_imm, 3);
        check("addi_rob", alu_rob_pos, 2);
        check("addi_op", alu_opcode, OP_IMM);
        check("addi_pc", alu_pc, 32'h100);
        tick();
        check("addi_pulse", alu_en, 0);

        // ADD pending on ROB 3
        issue_set(4'd4, OP, 32'd0, 5'h13, 32'd4, 5'h00, 32'd0, 32'h104);
        tick(); quiet();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("add_wait", alu_en, 0);
        end
        alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'hAA;
        tick(); quiet();
        check("add_woke", alu_en, 0);
        tick();
        check("add_en", alu_en, 1);
        check("add_val1", alu_val1, 32'hAA);
        check("add_val2", alu_val2, 4);
        check("add_rob", alu_rob_pos, 4);
        tick();
        check("add_pulse", alu_en, 0);

        // Both broadcasts resolve incoming tags during issue
        issue_set(4'd7, OP, 32'd0, 5'h15, 32'd0, 5'h16, 32'd0, 32'h108);
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd5; lsb_result_val = 32'd7;
        alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'd9;
        tick(); quiet();
        check("byp_lat1", alu_en, 0);
        tick();
        check("byp_en", alu_en, 1);
        check("byp_val1", alu_val1, 7);
        check("byp_val2", alu_val2, 9);
        tick();

        // Fill 16 entries pending on ROB 1
        for (int i = 0; i < 16; i++) begin
            issue_set(4'(i), OP, 32'd0, 5'h11, 32'd1, 5'h00, 32'd0, 32'h200 + 32'(i));
            #1;
            check("fill_full", rs_nxt_full, (i == 15) ? 64'd1 : 64'd0);
            tick();
        end
        quiet();
        #1;
        check("full_hold", rs_nxt_full, 1);
        check("fill_nodisp", alu_en, 0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd1; alu_result_val = 32'h77;
        tick(); quiet();
        check("drain_lat", alu_en, 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("drain_en", alu_en, 1);
            check("drain_rob", alu_rob_pos, 64'(k));
            check("drain_val1", alu_val1, 32'h77);
            if (k < 2) begin
                check("drain_full_idle", rs_nxt_full, 0);
                rs_en = 1'b1;
                #1;
                check("drain_full_issue", rs_nxt_full, (k == 0) ? 64'd1 : 64'd0);
                rs_en = 1'b0;
                #1;
            end
        end
        tick();
        check("drain_end", alu_en, 0);

        // Rollback with 10 busy (the last one ready) and a ready issue in the flush cycle
        for (int i = 0; i < 10; i++) begin
            issue_set(4'(i), OP, 32'd0, (i == 9) ? 5'h00 : 5'h1F, 32'd0, 5'h00, 32'd0, 32'h300);
            tick();
        end
        issue_set(4'hC, OP, 32'd1, 5'h00, 32'd1, 5'h00, 32'd0, 32'h400);
        rollback = 1'b1;
        tick(); quiet();
        check("rb_en", alu_en, 0);
        check("rb_full", rs_nxt_full, 0);
        tick();
        check("rb_noissue", alu_en, 0);
        alu_result = 1'b1; alu_result_rob_pos = 4'hF; alu_result_val = 32'h5;
        tick(); quiet();
        tick();
        check("rb_cleared1", alu_en, 0);
        tick();
        check("rb_cleared2", alu_en, 0);
        issue_set(4'd3, OP, 32'h33, 5'h00, 32'd0, 5'h00, 32'd0, 32'h500);
        tick(); quiet();
        check("rb_new_lat", alu_en, 0);
        tick();
        check("rb_new_en", alu_en, 1);
        check("rb_new_rob", alu_rob_pos, 3);

        // rdy stall while a dispatch is on the output and another entry is ready
        issue_set(4'd5, OP, 32'h55, 5'h00, 32'd0, 5'h00, 32'd0, 32'h600);
        tick();
        issue_set(4'd6, OP, 32'h66, 5'h00, 32'd0, 5'h00, 32'd0, 32'h604);
        tick(); quiet();
        check("stall_pre_en", alu_en, 1);
        check("stall_pre_rob", alu_rob_pos, 5);
        rdy = 1'b0;
        alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_en", alu_en, 1);
            check("stall_rob", alu_rob_pos, 5);
            check("stall_val1", alu_val1, 32'h55);
        end
        rdy = 1'b1; quiet();
        tick();
        check("resume_en", alu_en, 1);
        check("resume_rob", alu_rob_pos, 6);
        check("resume_val1", alu_val1, 32'h66);
        tick();
        check("resume_pulse", alu_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
